// File: rtl/systolic_pkg.sv
// Shared constants and tag layout for the systolic MAC datapath.
package systolic_pkg;

   localparam int MUL_LAT_MIN = 1;
   localparam int MUL_LAT_MAX = 8;

   // One entry of the tag line that shadows the multiplier pipeline.
   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

   // The accumulator must be at least as wide as the product it sums.
   function automatic bit acc_width_ok(input int prod_w, input int acc_w);
      return acc_w >= prod_w;
   endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Operand/result handshake bundle between the multiplier side, the
// accumulator and the downstream result consumer.
interface mac_accumulator_if #(
   parameter int PROD_W = 32,
   parameter int ACC_W  = 40,
   parameter int CNT_W  = 8
);
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic              pip_en;
   logic [PROD_W-1:0] mul_out;
   logic              acc_clear;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic              out_sat;
   logic [CNT_W-1:0]  out_count;

   modport master (
      output in_valid, in_last, mul_out, acc_clear, out_ready,
      input  in_ready, pip_en, out_valid, out_data, out_sat, out_count
   );

   modport slave (
      input  in_valid, in_last, mul_out, acc_clear, out_ready,
      output in_ready, pip_en, out_valid, out_data, out_sat, out_count
   );
endinterface

// File: rtl/mac_tag_pipe.sv
// Tag delay line that tracks {valid, last} alongside the multiplier stages.
// Advances only on shift_i; flush_i wipes every entry, including the one
// being loaded on the same edge.
module mac_tag_pipe
   import systolic_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic shift_i,
   input  logic flush_i,
   input  tag_t tag_i,
   output tag_t tail_o
);

   tag_t [DEPTH-1:0] tag_q, tag_d;

   // Next tag line: flush dominates, otherwise shift toward the tail.
   always_comb begin
      tag_d = tag_q;
      if (flush_i) begin
         tag_d = '0;
      end else if (shift_i) begin
         tag_d[0] = tag_i;
         for (int k = 1; k < DEPTH; k++) tag_d[k] = tag_q[k-1];
      end
   end

   // Tag line register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tag_q <= '0;
      else        tag_q <= tag_d;
   end

   assign tail_o = tag_q[DEPTH-1];

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product accumulator behind a pipelined multiplier: saturating sum,
// sticky saturation flag, term counter and a single result holding register.
module mac_accumulator
   import systolic_pkg::*;
#(
   parameter int PROD_W  = 32,
   parameter int ACC_W   = 40,
   parameter int SIGNED  = 0,
   parameter int MUL_LAT = 1,
   parameter int CNT_W   = 8
) (
   input logic               clk,
   input logic               rst_n,
   mac_accumulator_if.slave  bus
);

   if (!acc_width_ok(PROD_W, ACC_W)) begin : g_bad_width
      $error("mac_accumulator: ACC_W must be >= PROD_W");
   end
   if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_bad_lat
      $error("mac_accumulator: MUL_LAT out of range 1..8");
   end

   localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] S_MIN = ~S_MAX;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             sat_q, sat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic             out_sat_q, out_sat_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;

   logic             pip_en;
   tag_t             new_tag, tail;
   logic [ACC_W-1:0] prod_ext, sat_sum;
   logic [ACC_W:0]   sum_raw;
   logic             ovf;
   logic [CNT_W-1:0] cnt_inc;

   // Pipeline moves whenever the holding register can take a new result.
   assign pip_en        = ~out_valid_q | bus.out_ready;
   assign bus.in_ready  = pip_en;
   assign bus.pip_en    = pip_en;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.out_count = out_count_q;

   assign new_tag.valid = bus.in_valid;
   assign new_tag.last  = bus.in_valid & bus.in_last;

   mac_tag_pipe #(.DEPTH(MUL_LAT)) u_tags (
      .clk     (clk),
      .rst_n   (rst_n),
      .shift_i (pip_en),
      .flush_i (bus.acc_clear),
      .tag_i   (new_tag),
      .tail_o  (tail)
   );

   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   // Extend the product and form the clamped sum plus its overflow flag.
   always_comb begin
      if (SIGNED != 0) prod_ext = ACC_W'($signed(bus.mul_out));
      else             prod_ext = ACC_W'(bus.mul_out);
      sum_raw = {1'b0, acc_q} + {1'b0, prod_ext};
      sat_sum = sum_raw[ACC_W-1:0];
      ovf     = 1'b0;
      if (SIGNED != 0) begin
         if ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
             (sum_raw[ACC_W-1] != acc_q[ACC_W-1])) begin
            ovf     = 1'b1;
            sat_sum = acc_q[ACC_W-1] ? S_MIN : S_MAX;
         end
      end else if (sum_raw[ACC_W]) begin
         ovf     = 1'b1;
         sat_sum = '1;
      end
   end

   // Accumulate the tail product, hand a finished dot product to the
   // holding register, and honour clear ahead of accumulation.
   always_comb begin
      acc_d       = acc_q;
      sat_d       = sat_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q & ~bus.out_ready;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_count_d = out_count_q;
      if (bus.acc_clear) begin
         acc_d = '0;
         sat_d = 1'b0;
         cnt_d = '0;
      end else if (pip_en && tail.valid) begin
         if (tail.last) begin
            out_valid_d = 1'b1;
            out_data_d  = sat_sum;
            out_sat_d   = sat_q | ovf;
            out_count_d = cnt_inc;
            acc_d       = '0;
            sat_d       = 1'b0;
            cnt_d       = '0;
         end else begin
            acc_d = sat_sum;
            sat_d = sat_q | ovf;
            cnt_d = cnt_inc;
         end
      end
   end

   // Accumulator and result registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         sat_q       <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_count_q <= '0;
      end else begin
         acc_q       <= acc_d;
         sat_q       <= sat_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_count_q <= out_count_d;
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: three configurations, a pipelined multiplier
// stand-in, and a queue-based model of in-flight terms.
module tb_mac_accumulator;

   // {PROD_W, ACC_W, SIGNED, MUL_LAT, CNT_W} per instance
   localparam int PW0 = 32, AW0 = 34, SG0 = 0, LT0 = 1, CW0 = 8;
   localparam int PW1 = 8,  AW1 = 8,  SG1 = 1, LT1 = 2, CW1 = 8;
   localparam int PW2 = 16, AW2 = 18, SG2 = 1, LT2 = 3, CW2 = 3;
   localparam int CFG [3][5] = '{'{PW0, AW0, SG0, LT0, CW0},
                                 '{PW1, AW1, SG1, LT1, CW1},
                                 '{PW2, AW2, SG2, LT2, CW2}};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  iv = '0, il = '0, clr = '0, ordy = '1;
   longint      prod_in [3];
   logic [63:0] mpipe [3][8];
   logic [2:0]  pe_v;

   always #5 clk = ~clk;

   mac_accumulator_if #(.PROD_W(PW0), .ACC_W(AW0), .CNT_W(CW0)) if0 ();
   mac_accumulator_if #(.PROD_W(PW1), .ACC_W(AW1), .CNT_W(CW1)) if1 ();
   mac_accumulator_if #(.PROD_W(PW2), .ACC_W(AW2), .CNT_W(CW2)) if2 ();

   assign if0.in_valid = iv[0]; assign if0.in_last = il[0];
   assign if0.acc_clear = clr[0]; assign if0.out_ready = ordy[0];
   assign if0.mul_out = mpipe[0][LT0-1][PW0-1:0];
   assign if1.in_valid = iv[1]; assign if1.in_last = il[1];
   assign if1.acc_clear = clr[1]; assign if1.out_ready = ordy[1];
   assign if1.mul_out = mpipe[1][LT1-1][PW1-1:0];
   assign if2.in_valid = iv[2]; assign if2.in_last = il[2];
   assign if2.acc_clear = clr[2]; assign if2.out_ready = ordy[2];
   assign if2.mul_out = mpipe[2][LT2-1][PW2-1:0];
   assign pe_v = {if2.pip_en, if1.pip_en, if0.pip_en};

   mac_accumulator #(.PROD_W(PW0), .ACC_W(AW0), .SIGNED(SG0), .MUL_LAT(LT0), .CNT_W(CW0))
      u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   mac_accumulator #(.PROD_W(PW1), .ACC_W(AW1), .SIGNED(SG1), .MUL_LAT(LT1), .CNT_W(CW1))
      u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   mac_accumulator #(.PROD_W(PW2), .ACC_W(AW2), .SIGNED(SG2), .MUL_LAT(LT2), .CNT_W(CW2))
      u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   // Multiplier stand-in: the product presented with an operand pair
   // emerges MUL_LAT pip_en pulses later.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (pe_v[d]) begin
            for (int k = 7; k > 0; k--) mpipe[d][k] <= mpipe[d][k-1];
            mpipe[d][0] <= prod_in[d];
         end
      end
   end

   // ---------------- behavioural model ----------------
   typedef struct {
      int     d;
      longint due;
      longint prod;
      bit     last;
   } term_t;

   term_t  fly[$];
   longint macc [3], mod [3], pulse [3];
   bit     msat [3], mov [3], mos [3];
   int     mcnt [3], moc [3];

   int     checks = 0, errors = 0, cyc = 0, stall_cnt;
   int     vcyc [3], fst_cyc [3], lst_cyc [3], last_cnt [3];
   longint fst_data [3], last_data [3];
   bit     last_sat [3];

   function automatic longint mask(int w);
      return (longint'(1) << w) - 1;
   endfunction

   function automatic longint sx(int d, longint p);
      longint v;
      int     w;
      w = CFG[d][0];
      v = p & mask(w);
      if (CFG[d][2] != 0 && v[w-1]) v = v - (longint'(1) << w);
      return v;
   endfunction

   function automatic void model_reset();
      fly.delete();
      for (int d = 0; d < 3; d++) begin
         macc[d] = 0; msat[d] = 0; mcnt[d] = 0; pulse[d] = 0;
         mov[d] = 0; mod[d] = 0; mos[d] = 0; moc[d] = 0;
      end
   endfunction

   // State after one rising edge given the inputs currently driven.
   function automatic void model_edge(int d);
      bit     pe, hit, load, ov;
      term_t  t;
      longint s, hi, lo;
      int     aw, ncnt;
      pe = !mov[d] || ordy[d];
      hit = 0; load = 0;
      aw = CFG[d][1];
      if (CFG[d][2] != 0) begin
         hi = (longint'(1) << (aw-1)) - 1; lo = -(longint'(1) << (aw-1));
      end else begin
         hi = mask(aw); lo = 0;
      end
      if (clr[d]) begin
         for (int i = fly.size()-1; i >= 0; i--) if (fly[i].d == d) fly.delete(i);
         macc[d] = 0; msat[d] = 0; mcnt[d] = 0;
      end else if (pe) begin
         pulse[d]++;
         for (int i = 0; i < fly.size(); i++) begin
            if (fly[i].d == d && fly[i].due == pulse[d]) begin
               t = fly[i]; hit = 1; fly.delete(i); break;
            end
         end
         if (hit) begin
            s = macc[d] + sx(d, t.prod);
            ov = (s > hi) || (s < lo);
            if (s > hi) s = hi;
            if (s < lo) s = lo;
            ncnt = (mcnt[d] + 1 > (1 << CFG[d][4]) - 1) ? mcnt[d] : mcnt[d] + 1;
            if (t.last) begin
               load = 1; mod[d] = s; mos[d] = msat[d] | ov; moc[d] = ncnt;
               macc[d] = 0; msat[d] = 0; mcnt[d] = 0;
            end else begin
               macc[d] = s; msat[d] = msat[d] | ov; mcnt[d] = ncnt;
            end
         end
         if (iv[d]) fly.push_back(term_t'{d, pulse[d] + CFG[d][3], prod_in[d], il[d]});
      end
      if (load)         mov[d] = 1;
      else if (ordy[d]) mov[d] = 0;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(string nm, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic compare_all();
      bit     ir [3], pe [3], ov [3], os [3];
      longint od [3], oc [3];
      bit     mpe;
      ir[0] = if0.in_ready; pe[0] = if0.pip_en; ov[0] = if0.out_valid;
      os[0] = if0.out_sat;  od[0] = longint'(if0.out_data); oc[0] = longint'(if0.out_count);
      ir[1] = if1.in_ready; pe[1] = if1.pip_en; ov[1] = if1.out_valid;
      os[1] = if1.out_sat;  od[1] = longint'(if1.out_data); oc[1] = longint'(if1.out_count);
      ir[2] = if2.in_ready; pe[2] = if2.pip_en; ov[2] = if2.out_valid;
      os[2] = if2.out_sat;  od[2] = longint'(if2.out_data); oc[2] = longint'(if2.out_count);
      for (int d = 0; d < 3; d++) begin
         mpe = !mov[d] || ordy[d];
         chk($sformatf("d%0d in_ready c%0d", d, cyc), ir[d], mpe);
         chk($sformatf("d%0d pip_en c%0d", d, cyc), pe[d], mpe);
         chk($sformatf("d%0d out_valid c%0d", d, cyc), ov[d], mov[d]);
         chk($sformatf("d%0d out_data c%0d", d, cyc), od[d], mod[d] & mask(CFG[d][1]));
         chk($sformatf("d%0d out_sat c%0d", d, cyc), os[d], mos[d]);
         chk($sformatf("d%0d out_count c%0d", d, cyc), oc[d], moc[d]);
         if (ov[d]) begin
            if (vcyc[d] == 0) begin fst_cyc[d] = cyc; fst_data[d] = od[d]; end
            lst_cyc[d] = cyc; vcyc[d]++;
            last_data[d] = od[d]; last_sat[d] = os[d]; last_cnt[d] = int'(oc[d]);
         end
      end
   endtask

   task automatic step();
      if (!rst_n) model_reset();
      else for (int d = 0; d < 3; d++) model_edge(d);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      compare_all();
   endtask

   task automatic idle(int n);
      repeat (n) step();
   endtask

   // Present one term and hold it until the block takes it.
   task automatic send(int d, longint p, bit last);
      int n;
      n = 0;
      iv[d] = 1; il[d] = last; prod_in[d] = p;
      while (!(!mov[d] || ordy[d]) && n < 200) begin step(); n++; end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL d%0d send timeout: got no acceptance expected acceptance", d);
      end
      step();
      iv[d] = 0; il[d] = 0;
   endtask

   function automatic longint rnd_prod(int d);
      case (d)
         0:       return ($urandom_range(2) == 0) ? 64'hFFFF_0000 + $urandom_range(65535)
                                                  : longint'($urandom_range(999));
         1:       return longint'($urandom_range(255));
         default: return ($urandom_range(1) == 0) ? (($urandom_range(1) == 0) ? 64'h7FFF : 64'h8000)
                                                  : longint'($urandom_range(65535));
      endcase
   endfunction

   function automatic void clr_obs(int d);
      vcyc[d] = 0; fst_cyc[d] = 0; lst_cyc[d] = 0; fst_data[d] = 0;
      last_data[d] = 0; last_sat[d] = 0; last_cnt[d] = 0;
   endfunction

   initial begin
      for (int d = 0; d < 3; d++) begin prod_in[d] = 0; clr_obs(d); end
      model_reset();
      @(negedge clk);
      compare_all();
      chk("reset in_ready", if0.in_ready, 1);
      chk("reset out_data", longint'(if1.out_data), 0);
      rst_n = 1;
      idle(2);

      // 3 + 5 + 7 unsigned, single-cycle result
      clr_obs(0);
      send(0, 3, 0); send(0, 5, 0); send(0, 7, 1); idle(4);
      chk("basic sum", last_data[0], 15);
      chk("basic count", last_cnt[0], 3);
      chk("basic sat", last_sat[0], 0);
      chk("basic valid cycles", vcyc[0], 1);

      // signed 8-bit saturation, then clean follow-up
      send(1, 100, 0); send(1, 100, 1); idle(5);
      chk("sat value", last_data[1], 127);
      chk("sat flag", last_sat[1], 1);
      send(1, -20, 1); idle(5);
      chk("neg value", last_data[1], 236);
      chk("neg sat", last_sat[1], 0);

      // result held with out_ready low while a term waits
      send(0, 9, 1); ordy[0] = 0; idle(2);
      iv[0] = 1; il[0] = 0; prod_in[0] = 4; stall_cnt = 0;
      repeat (5) begin
         step();
         if (!if0.in_ready && !if0.pip_en) stall_cnt++;
      end
      chk("stall cycles", stall_cnt, 5);
      chk("held result", last_data[0], 9);
      ordy[0] = 1; step(); iv[0] = 0;
      send(0, 6, 1); idle(4);
      chk("post-stall sum", last_data[0], 10);
      chk("post-stall count", last_cnt[0], 2);

      // clear after two terms, with a term accepted on the clear cycle
      send(2, 1000, 0); send(2, 2000, 0);
      clr[2] = 1; iv[2] = 1; prod_in[2] = 500; step();
      clr[2] = 0; iv[2] = 0;
      send(2, 30, 0); send(2, 40, 1); idle(6);
      chk("clear sum", last_data[2], 70);
      chk("clear count", last_cnt[2], 2);

      // asynchronous reset mid-pipeline
      send(2, 7, 0); send(2, 8, 1);
      #2 rst_n = 0;
      model_reset();
      #1 compare_all();
      chk("rst out_valid", if2.out_valid, 0);
      step();
      rst_n = 1;
      clr_obs(2);
      idle(8);
      chk("no spurious valid", vcyc[2], 0);
      send(2, 5, 1); idle(6);
      chk("post-reset result", last_data[2], 5);
      chk("post-reset count", last_cnt[2], 1);

      // back-to-back single-term results
      clr_obs(0);
      send(0, 11, 1); send(0, 22, 1); idle(4);
      chk("b2b valid cycles", vcyc[0], 2);
      chk("b2b gap", lst_cyc[0] - fst_cyc[0], 1);
      chk("b2b first", fst_data[0], 11);
      chk("b2b second", last_data[0], 22);

      // count saturation at CNT_W=3: nine small terms
      for (int i = 0; i < 8; i++) send(2, 1, 0);
      send(2, 1, 1); idle(6);
      chk("count saturates", last_cnt[2], 7);
      chk("count-sat sum", last_data[2], 9);

      // randomized traffic per instance
      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 400; n++) begin
            iv[d]   = ($urandom_range(3) != 0);
            il[d]   = ($urandom_range(4) == 0);
            clr[d]  = ($urandom_range(39) == 0);
            ordy[d] = ($urandom_range(3) != 0);
            prod_in[d] = rnd_prod(d);
            step();
         end
         iv[d] = 0; il[d] = 0; clr[d] = 0; ordy[d] = 1;
         idle(12);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 32, meaning width of the multiplier product input.
REQ-002 SHALL have parameter ACC_W, default 40, meaning accumulator and result width; a value below PROD_W SHALL be an elaboration error.
REQ-003 SHALL have parameter SIGNED, default 0, meaning the product is two's complement (1) or unsigned (0).
REQ-004 SHALL have parameter MUL_LAT, default 1, meaning the multiplier latency in pip_en pulses (multiplier STAGE+1), range 1..8.
REQ-005 SHALL have parameter CNT_W, default 8, meaning the term-counter width.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  operand pair presented to the multiplier this cycle.
REQ-009 in_last  in  1  qualifies in_valid; marks the final term of a dot product.
REQ-010 in_ready  out  1  this block accepts an operand pair this cycle.
REQ-011 pip_en  out  1  multiplier pipeline advance enable; SHALL equal in_ready.
REQ-012 mul_out  in  PROD_W  registered multiplier product.
REQ-013 acc_clear  in  1  synchronous abort of the current dot product.
REQ-014 out_valid  out  1  result holding register full.
REQ-015 out_ready  in  1  downstream consumes the result when high together with out_valid.
REQ-016 out_data  out  ACC_W  dot-product result.
REQ-017 out_sat  out  1  result saturated.
REQ-018 out_count  out  CNT_W  number of terms in the result, saturating at all-ones.

Function
REQ-019 in_ready SHALL be (~out_valid | out_ready); an operand pair SHALL be accepted when in_valid and in_ready are both high.
REQ-020 A tag line of MUL_LAT entries {valid, last} SHALL shift only when pip_en is high; it SHALL load {in_valid, in_valid & in_last} at entry 0.
REQ-021 When pip_en is high and the tail tag is valid, mul_out SHALL be added to the accumulator exactly once.
REQ-022 mul_out SHALL be sign-extended to ACC_W when SIGNED=1 and zero-extended otherwise.
REQ-023 On overflow, the accumulator SHALL clamp to max/min (signed) or all-ones (unsigned) and SHALL set a sticky sat flag for the current dot product.
REQ-024 When the tail tag has last set, the value acc+mul_out (saturated), the sat flag and the term count SHALL load the output register, out_valid SHALL go to 1, and acc, sat and count SHALL reset to 0 on the same edge.
REQ-025 Latency SHALL be MUL_LAT+1 cycles from acceptance of the last term to out_valid when no stall occurs.
REQ-026 out_valid SHALL clear on an out_valid & out_ready cycle unless a new result loads on the same edge; in that case the new result SHALL be held (back-to-back results with no gap).
REQ-027 While out_valid & ~out_ready, pip_en SHALL be 0; the tag line, the accumulator and the multiplier SHALL freeze, and no product SHALL be lost or double-counted.
REQ-028 acc_clear SHALL zero acc, sat and count, invalidate every tag including the one accepted in the same cycle, and SHALL leave the output register untouched; acc_clear SHALL have priority over a simultaneous tail-tag accumulation.
REQ-029 in_last without in_valid SHALL be ignored.
REQ-030 A single-term dot product (in_last on the first term) SHALL yield that product.

Reset
REQ-031 rst_n low SHALL asynchronously clear all tags, acc, sat, count, out_valid, out_data, out_sat and out_count to 0.
REQ-032 After reset, in_ready and pip_en SHALL be 1.
REQ-033 Reset asserted mid-dot-product SHALL discard all in-flight terms; the first result after reset SHALL contain only terms accepted after reset.

Structure
REQ-034 ACC_W/PROD_W width check constants and the {valid, last} tag field layout SHALL live in shared package systolic_pkg.
REQ-035 The tag delay line SHALL be a sub-module mac_tag_pipe (parameters DEPTH and enable; inputs shift and flush).

Verification
REQ-036 SIGNED=0, MUL_LAT=1; products 3, 5, 7 with last on 7; out_ready=1 -> out_data=15, out_count=3, out_sat=0, out_valid for 1 cycle.
REQ-037 SIGNED=1, ACC_W=PROD_W=8; products 100, 100, last -> out_data=127 and out_sat=1; the next dot product -20 (last) -> -20 and out_sat=0.
REQ-038 Result pending with out_ready=0 for 5 cycles while in_valid is held -> in_ready=pip_en=0 throughout; after release, the next result sum is exact.
REQ-039 acc_clear after 2 of 4 terms -> terms 1-2 are discarded; after the clear, terms 3, 4 (last) produce only their sum.
REQ-040 rst_n pulsed mid-pipeline with MUL_LAT=3 -> all outputs are 0; no spurious out_valid follows.
REQ-041 Two single-term dot products accepted back-to-back with out_ready=1 -> two consecutive out_valid cycles with correct values.
